// File: rtl/periph_bus_ctrl_pkg.sv
// Shared SoC definitions for the peripheral bus controller.
//   - device indices and count (bit positions in dev_stb / dev_ack)
//   - default bus width
//   - controller state encoding
//   - access timer width (wide enough for any legal TIMEOUT up to 255)
package periph_bus_ctrl_pkg;

    localparam int unsigned DEV_BOOT     = 0;
    localparam int unsigned DEV_SPI      = 1;
    localparam int unsigned DEV_UART     = 2;
    localparam int unsigned DEV_GPIO     = 3;
    localparam int unsigned NUM_DEV      = 4;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned TIMER_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/periph_bus_ctrl_access_timer.sv
// access_timer: wait-cycle counter for one device access.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : force the count to zero (held while no access is running)
//   en         : count one cycle
//   expired    : count has reached LIMIT-1, i.e. this is the LIMIT-th access cycle
module access_timer
    import periph_bus_ctrl_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = (count == TIMER_W'(LIMIT - 1));

endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: single-outstanding bridge from the core request channel to
// four memory-mapped devices (boot, spi, uart, gpio).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/ready/we/addr/wdata : core request channel
//   *_dev_sel                  : address-decoder selects for req_addr
//   dev_stb/we/addr/wdata      : registered device-side request, one-hot strobe
//   dev_ack, dev_rdata         : per-device completion and read data slices
//   rsp_valid/ready/rdata/err  : response channel back to the core
module periph_bus_ctrl
    import periph_bus_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [XLEN-1:0]         req_addr,
    input  logic [XLEN-1:0]         req_wdata,
    input  logic                    boot_dev_sel,
    input  logic                    spi_dev_sel,
    input  logic                    uart_dev_sel,
    input  logic                    gpio_dev_sel,
    output logic [NUM_DEV-1:0]      dev_stb,
    output logic                    dev_we,
    output logic [XLEN-1:0]         dev_addr,
    output logic [XLEN-1:0]         dev_wdata,
    input  logic [NUM_DEV-1:0]      dev_ack,
    input  logic [NUM_DEV*XLEN-1:0] dev_rdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [XLEN-1:0]         rsp_rdata,
    output logic                    rsp_err
);

    state_e             state, state_next;
    logic [NUM_DEV-1:0] sel_in, sel_q;
    logic               accept, sel_ok, ack_hit, timer_expired;
    logic [XLEN-1:0]    ack_rdata;

    assign sel_in  = {gpio_dev_sel, uart_dev_sel, spi_dev_sel, boot_dev_sel};
    assign sel_ok  = $onehot(sel_in);
    assign accept  = req_valid && req_ready;
    // Acks from devices that were not strobed are masked off here.
    assign ack_hit = |(dev_ack & sel_q);

    access_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != ST_ACCESS),
        .en      (state == ST_ACCESS),
        .expired (timer_expired)
    );

    // sel_q is one-hot whenever ACCESS is reached, so an OR of masked slices
    // is the selected device's read data.
    always_comb begin
        ack_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_q[i]) begin
                ack_rdata = ack_rdata | dev_rdata[i*XLEN +: XLEN];
            end
        end
    end

    // State register. Reset forces IDLE, which drops the strobe and any
    // pending response on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting every comb output first keeps unlisted paths from
        // inferring a latch.
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = sel_ok ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (ack_hit || timer_expired) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        dev_stb   = (state == ST_ACCESS) ? sel_q : '0;
    end

    // Request capture and response capture. Acceptance only happens in IDLE
    // and completion only in ACCESS, so the two branches never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dev_we    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            sel_q     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                dev_we    <= req_we;
                dev_addr  <= req_addr;
                dev_wdata <= req_wdata;
                sel_q     <= sel_in;
                if (!sel_ok) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
            if (state == ST_ACCESS) begin
                // An ack in the timeout cycle still completes normally.
                if (ack_hit) begin
                    rsp_rdata <= ack_rdata;
                    rsp_err   <= 1'b0;
                end else if (timer_expired) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Directed bench for periph_bus_ctrl. Inputs change and outputs are sampled
// 1 ns after each rising edge. Cycle numbering below: the cycle in which
// req_valid && req_ready is seen is the acceptance cycle; "ACCESS n" is the
// n-th cycle with the strobe up.
module tb_periph_bus_ctrl;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we;
    logic [XLEN-1:0]   req_addr, req_wdata;
    logic              boot_dev_sel, spi_dev_sel, uart_dev_sel, gpio_dev_sel;
    logic [3:0]        dev_stb;
    logic              dev_we;
    logic [XLEN-1:0]   dev_addr, dev_wdata;
    logic [3:0]        dev_ack;
    logic [4*XLEN-1:0] dev_rdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [XLEN-1:0]   rsp_rdata;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    periph_bus_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .boot_dev_sel (boot_dev_sel),
        .spi_dev_sel  (spi_dev_sel),
        .uart_dev_sel (uart_dev_sel),
        .gpio_dev_sel (gpio_dev_sel),
        .dev_stb      (dev_stb),
        .dev_we       (dev_we),
        .dev_addr     (dev_addr),
        .dev_wdata    (dev_wdata),
        .dev_ack      (dev_ack),
        .dev_rdata    (dev_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge, then drop it and the selects.
    task automatic request(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] sel);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        {gpio_dev_sel, uart_dev_sel, spi_dev_sel, boot_dev_sel} = sel;
        step();
        req_valid    = 1'b0;
        {gpio_dev_sel, uart_dev_sel, spi_dev_sel, boot_dev_sel} = 4'b0000;
    endtask

    // Accept the pending response and return to IDLE.
    task automatic drain(input string tag);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int strobes;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        {gpio_dev_sel, uart_dev_sel, spi_dev_sel, boot_dev_sel} = 4'b0000;
        dev_ack   = 4'b0000;
        dev_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hDEAD_0000};
        rsp_ready = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        rst_n = 1'b1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_dev_stb",   {28'd0, dev_stb},   32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata,          32'd0);
        check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("rst_dev_addr",  dev_addr,           32'd0);
        check("rst_dev_we",    {31'd0, dev_we},    32'd0);

        // ---------------- UART read, ack in ACCESS 2 ----------------
        dev_rdata[2*XLEN +: XLEN] = 32'hA5A5_0001;
        request(1'b0, 32'h1000_0200, 32'h0, 4'b0100);
        // ACCESS 1
        check("uart_stb_a1",    {28'd0, dev_stb},   32'h4);
        check("uart_ready_a1",  {31'd0, req_ready}, 32'd0);
        check("uart_addr",      dev_addr,           32'h1000_0200);
        check("uart_we",        {31'd0, dev_we},    32'd0);
        check("uart_valid_a1",  {31'd0, rsp_valid}, 32'd0);
        step();
        // ACCESS 2: ack here
        check("uart_stb_a2",    {28'd0, dev_stb},   32'h4);
        dev_ack = 4'b0100;
        step();
        dev_ack = 4'b0000;
        // RESP
        check("uart_valid",     {31'd0, rsp_valid}, 32'd1);
        check("uart_rdata",     rsp_rdata,          32'hA5A5_0001);
        check("uart_err",       {31'd0, rsp_err},   32'd0);
        check("uart_stb_resp",  {28'd0, dev_stb},   32'd0);
        check("uart_ready_resp",{31'd0, req_ready}, 32'd0);
        drain("uart");
        check("uart_valid_idle",{31'd0, rsp_valid}, 32'd0);

        // ---------------- GPIO write, ack in ACCESS 1 ----------------
        dev_rdata[3*XLEN +: XLEN] = 32'h1234_5678;
        request(1'b1, 32'h2000_0004, 32'h0000_00FF, 4'b1000);
        check("gpio_stb_a1",    {28'd0, dev_stb},   32'h8);
        check("gpio_we",        {31'd0, dev_we},    32'd1);
        check("gpio_wdata",     dev_wdata,          32'h0000_00FF);
        dev_ack = 4'b1000;
        step();
        dev_ack = 4'b0000;
        check("gpio_stb_drop",  {28'd0, dev_stb},   32'd0);
        check("gpio_valid",     {31'd0, rsp_valid}, 32'd1);
        check("gpio_err",       {31'd0, rsp_err},   32'd0);
        check("gpio_rdata",     rsp_rdata,          32'h1234_5678);
        drain("gpio");

        // ---------------- no select -> decode error ----------------
        request(1'b0, 32'hF000_0000, 32'h0, 4'b0000);
        check("nosel_stb",      {28'd0, dev_stb},   32'd0);
        check("nosel_valid",    {31'd0, rsp_valid}, 32'd1);
        check("nosel_err",      {31'd0, rsp_err},   32'd1);
        check("nosel_rdata",    rsp_rdata,          32'd0);
        check("nosel_ready",    {31'd0, req_ready}, 32'd0);
        drain("nosel");

        // ---------------- two selects -> decode error ----------------
        request(1'b0, 32'h3000_0000, 32'h0, 4'b0110);
        check("multi_stb",      {28'd0, dev_stb},   32'd0);
        check("multi_valid",    {31'd0, rsp_valid}, 32'd1);
        check("multi_err",      {31'd0, rsp_err},   32'd1);
        drain("multi");

        // ---------------- SPI timeout, boot acking throughout ----------------
        dev_ack = 4'b0001;
        request(1'b0, 32'h4000_0010, 32'h0, 4'b0010);
        strobes = 0;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            if (dev_stb == 4'b0010) strobes++;
            step();
        end
        dev_ack = 4'b0000;
        check("tmo_strobes",    strobes,            32'd16);
        check("tmo_valid",      {31'd0, rsp_valid}, 32'd1);
        check("tmo_err",        {31'd0, rsp_err},   32'd1);
        check("tmo_rdata",      rsp_rdata,          32'd0);
        check("tmo_stb_resp",   {28'd0, dev_stb},   32'd0);
        drain("tmo");

        // ---------------- SPI ack on ACCESS 16 (timeout cycle) ----------------
        dev_rdata[1*XLEN +: XLEN] = 32'hC0DE_0016;
        request(1'b0, 32'h4000_0014, 32'h0, 4'b0010);
        for (int i = 0; i < 15; i++) step();
        // ACCESS 16
        check("late_stb_a16",   {28'd0, dev_stb},   32'h2);
        check("late_valid_a16", {31'd0, rsp_valid}, 32'd0);
        dev_ack = 4'b0010;
        step();
        dev_ack = 4'b0000;
        check("late_valid",     {31'd0, rsp_valid}, 32'd1);
        check("late_err",       {31'd0, rsp_err},   32'd0);
        check("late_rdata",     rsp_rdata,          32'hC0DE_0016);
        drain("late");

        // ---------------- reset in 3rd RESP cycle, rsp_ready low ----------------
        request(1'b0, 32'hF000_0004, 32'h0, 4'b0000);
        // RESP 1
        check("rr_valid_r1",    {31'd0, rsp_valid}, 32'd1);
        step();
        // RESP 2
        check("rr_valid_r2",    {31'd0, rsp_valid}, 32'd1);
        check("rr_err_r2",      {31'd0, rsp_err},   32'd1);
        step();
        // RESP 3: reset for one edge
        check("rr_valid_r3",    {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rr_valid_after", {31'd0, rsp_valid}, 32'd0);
        check("rr_ready_after", {31'd0, req_ready}, 32'd1);
        check("rr_err_after",   {31'd0, rsp_err},   32'd0);
        step();
        step();
        check("rr_valid_later", {31'd0, rsp_valid}, 32'd0);

        // ---------------- reset mid-ACCESS drops strobe ----------------
        request(1'b1, 32'h1000_0300, 32'h5555_AAAA, 4'b0100);
        check("ra_stb_a1",      {28'd0, dev_stb},   32'h4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("ra_stb_after",   {28'd0, dev_stb},   32'd0);
        check("ra_valid_after", {31'd0, rsp_valid}, 32'd0);
        check("ra_wdata_after", dev_wdata,          32'd0);
        check("ra_ready_after", {31'd0, req_ready}, 32'd1);
        dev_ack = 4'b0100;
        step();
        dev_ack = 4'b0000;
        check("ra_no_rsp",      {31'd0, rsp_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
